// File: rtl/fpadd_param.sv
// rtl/fpadd_param.sv - parametrised multi-cycle floating-point adder/subtractor
//
// Purpose: one-at-a-time IEEE-754-style add/sub with FTZ inputs, round to
// nearest even (guard/round/sticky) and NaN/Inf/zero handling.
// Ports:
//   clk, reset   rising-edge clock, synchronous active-high reset
//   start, op    one-cycle request (accepted in IDLE with done low); op=1 -> a-b
//   a, b         operands {sign, exp, frac}
//   sum          result, held from done until the next accepted start
//   busy         high while an operation is in flight
//   done         one-cycle pulse when sum is valid
// Option: define FPADD_FLAGS_EN to add flags[3:0] = {invalid, overflow,
//   underflow, inexact}, updated and held together with sum.
module fpadd_param #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic                   op,
  input  logic [EXP_W+MAN_W:0]   a,
  input  logic [EXP_W+MAN_W:0]   b,
  output logic [EXP_W+MAN_W:0]   sum,
  output logic                   busy,
  output logic                   done
`ifdef FPADD_FLAGS_EN
  ,
  output logic [3:0]             flags
`endif
);
  localparam int W  = EXP_W + MAN_W + 1;
  localparam int M  = MAN_W + 4;  // hidden+fraction+G/R/S in [M-1:0], carry in bit M
  localparam int EW = EXP_W + 2;  // headroom so exponent +1/-1 never wraps
  localparam logic [EXP_W-1:0] EXP_ONES = '1;
  localparam logic [W-1:0] QNAN = {1'b0, EXP_ONES, 1'b1, {(MAN_W-1){1'b0}}};

  typedef enum logic [2:0] {
    S_IDLE, S_SPECIAL, S_ALIGN, S_ADD, S_NORM, S_ROUND, S_DONE
  } state_t;

  state_t           state, state_n;
  logic             sa, sb, sa_n, sb_n;
  logic [EXP_W-1:0] ea, eb, ea_n, eb_n;
  logic [M:0]       ma, mb, ma_n, mb_n;
  logic [EW-1:0]    e_q, e_n;
  logic [W-1:0]     res_q, res_n, sum_n;
  logic             spec_q, spec_n, done_n;
`ifdef FPADD_FLAGS_EN
  logic [3:0]       fl_q, fl_n, flags_n;  // {invalid, overflow, underflow, inexact}
`endif

  // Special-case decode; denormals were already zeroed at capture.
  logic a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;
  assign a_zero = (ea == '0);
  assign b_zero = (eb == '0);
  assign a_inf  = (ea == EXP_ONES) && (ma[M-2:3] == '0);
  assign b_inf  = (eb == EXP_ONES) && (mb[M-2:3] == '0);
  assign a_nan  = (ea == EXP_ONES) && (ma[M-2:3] != '0);
  assign b_nan  = (eb == EXP_ONES) && (mb[M-2:3] != '0);

  // Alignment: larger magnitude becomes A. A shift past the whole mantissa
  // yields zero from the shift and all bits in sticky, i.e. sticky only.
  logic             swap;
  logic [M:0]       big_m, small_m, small_sh;
  logic [EXP_W-1:0] big_e, small_e, diff;
  assign swap     = {eb, mb} > {ea, ma};
  assign big_m    = swap ? mb : ma;
  assign small_m  = swap ? ma : mb;
  assign big_e    = swap ? eb : ea;
  assign small_e  = swap ? ea : eb;
  assign diff     = big_e - small_e;
  assign small_sh = (small_m >> diff)
                  | {{M{1'b0}}, |(small_m & ~({(M+1){1'b1}} << diff))};

  // Magnitude add/sub; after alignment ma >= mb so subtraction never goes negative.
  logic [M:0] add_res;
  assign add_res = (sa == sb) ? (ma + mb) : (ma - mb);

  // Round to nearest even on the normalised mantissa.
  logic             rnd_inc, rnd_ovf;
  logic [MAN_W+1:0] rnd_sum;
  logic [EW-1:0]    rnd_e;
  logic [MAN_W-1:0] rnd_frac;
  assign rnd_inc  = ma[2] & (ma[3] | ma[1] | ma[0]);
  assign rnd_sum  = {1'b0, ma[M-1:3]} + {{(MAN_W+1){1'b0}}, rnd_inc};
  assign rnd_e    = e_q + {{(EW-1){1'b0}}, rnd_sum[MAN_W+1]};
  assign rnd_frac = rnd_sum[MAN_W+1] ? rnd_sum[MAN_W:1] : rnd_sum[MAN_W-1:0];
  assign rnd_ovf  = (rnd_e >= {2'b00, EXP_ONES});

  assign busy = (state != S_IDLE);

  always_comb begin
    state_n = state;
    sa_n    = sa;
    sb_n    = sb;
    ea_n    = ea;
    eb_n    = eb;
    ma_n    = ma;
    mb_n    = mb;
    e_n     = e_q;
    res_n   = res_q;
    spec_n  = spec_q;
    sum_n   = sum;
    done_n  = 1'b0;
`ifdef FPADD_FLAGS_EN
    fl_n    = fl_q;
    flags_n = flags;
`endif
    case (state)
      S_IDLE: begin
        if (start && !done) begin
          sa_n    = a[W-1];
          sb_n    = b[W-1] ^ op;
          ea_n    = a[W-2:MAN_W];
          eb_n    = b[W-2:MAN_W];
          ma_n    = (a[W-2:MAN_W] == '0) ? '0 : {2'b01, a[MAN_W-1:0], 3'b000};
          mb_n    = (b[W-2:MAN_W] == '0) ? '0 : {2'b01, b[MAN_W-1:0], 3'b000};
          e_n     = '0;
          res_n   = '0;
          spec_n  = 1'b0;
          state_n = S_SPECIAL;
`ifdef FPADD_FLAGS_EN
          fl_n    = '0;
          flags_n = '0;
`endif
        end
      end
      S_SPECIAL: begin
        // Special results ride through ROUND untouched (spec_q) and on to DONE.
        spec_n  = 1'b1;
        state_n = S_ROUND;
        if (a_nan || b_nan || (a_inf && b_inf && (sa != sb))) begin
          res_n = QNAN;
`ifdef FPADD_FLAGS_EN
          fl_n[3] = 1'b1;
`endif
        end
        else if (a_inf)            res_n = {sa, ea, ma[M-2:3]};
        else if (b_inf)            res_n = {sb, eb, mb[M-2:3]};
        else if (a_zero && b_zero) res_n = {sa & sb, {(W-1){1'b0}}};
        else if (a_zero)           res_n = {sb, eb, mb[M-2:3]};
        else if (b_zero)           res_n = {sa, ea, ma[M-2:3]};
        else begin
          spec_n  = 1'b0;
          state_n = S_ALIGN;
        end
      end
      S_ALIGN: begin
        sa_n    = swap ? sb : sa;
        sb_n    = swap ? sa : sb;
        ma_n    = big_m;
        mb_n    = small_sh;
        e_n     = {2'b00, big_e};
        state_n = S_ADD;
      end
      S_ADD: begin
        if (add_res == '0) begin
          res_n   = '0;
          state_n = S_DONE;
        end else begin
          ma_n    = add_res;
          state_n = S_NORM;
        end
      end
      S_NORM: begin
        if (ma[M]) begin
          ma_n    = {1'b0, ma[M:2], ma[1] | ma[0]};
          e_n     = e_q + 1'b1;
          state_n = S_ROUND;
        end
        else if (ma[M-1]) begin
          state_n = S_ROUND;
        end
        else if (e_q == EW'(1)) begin
          // Next shift would land at exponent 0: flush to signed zero.
          res_n   = {sa, {(W-1){1'b0}}};
          state_n = S_DONE;
`ifdef FPADD_FLAGS_EN
          fl_n[1] = 1'b1;
          fl_n[0] = 1'b1;
`endif
        end
        else begin
          ma_n = ma << 1;
          e_n  = e_q - 1'b1;
        end
      end
      S_ROUND: begin
        state_n = S_DONE;
        if (!spec_q) begin
          if (rnd_ovf) res_n = {sa, EXP_ONES, {MAN_W{1'b0}}};
          else         res_n = {sa, rnd_e[EXP_W-1:0], rnd_frac};
`ifdef FPADD_FLAGS_EN
          fl_n[2] = rnd_ovf;
          fl_n[0] = rnd_ovf | (|ma[2:0]);
`endif
        end
      end
      S_DONE: begin
        sum_n   = res_q;
        done_n  = 1'b1;
        state_n = S_IDLE;
`ifdef FPADD_FLAGS_EN
        flags_n = fl_q;
`endif
      end
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= S_IDLE;
      sa     <= 1'b0;
      sb     <= 1'b0;
      ea     <= '0;
      eb     <= '0;
      ma     <= '0;
      mb     <= '0;
      e_q    <= '0;
      res_q  <= '0;
      spec_q <= 1'b0;
      sum    <= '0;
      done   <= 1'b0;
`ifdef FPADD_FLAGS_EN
      fl_q   <= '0;
      flags  <= '0;
`endif
    end else begin
      state  <= state_n;
      sa     <= sa_n;
      sb     <= sb_n;
      ea     <= ea_n;
      eb     <= eb_n;
      ma     <= ma_n;
      mb     <= mb_n;
      e_q    <= e_n;
      res_q  <= res_n;
      spec_q <= spec_n;
      sum    <= sum_n;
      done   <= done_n;
`ifdef FPADD_FLAGS_EN
      fl_q   <= fl_n;
      flags  <= flags_n;
`endif
    end
  end
endmodule

// File: tb/tb_fpadd_param.sv
// tb/tb_fpadd_param.sv - directed self-checking bench for fpadd_param
module tb_fpadd_param;
  logic        clk = 1'b0;
  logic        reset, start, op;
  logic [31:0] a, b, sum;
  logic        busy, done;
  logic        h_start, h_op;
  logic [15:0] h_a, h_b, h_sum;
  logic        h_busy, h_done;
`ifdef FPADD_FLAGS_EN
  logic [3:0]  flags, h_flags;
`endif
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fpadd_param dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
    .sum(sum), .busy(busy), .done(done)
`ifdef FPADD_FLAGS_EN
    , .flags(flags)
`endif
  );

  fpadd_param #(.EXP_W(5), .MAN_W(10)) dut_h (
    .clk(clk), .reset(reset), .start(h_start), .op(h_op), .a(h_a), .b(h_b),
    .sum(h_sum), .busy(h_busy), .done(h_done)
`ifdef FPADD_FLAGS_EN
    , .flags(h_flags)
`endif
  );

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic do_op(input logic [31:0] ia, input logic [31:0] ib, input logic iop,
                       output logic [31:0] res, output int lat);
    @(negedge clk);
    a = ia; b = ib; op = iop; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    lat = 0;
    while (done !== 1'b1 && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    res = sum;
  endtask

  task automatic test_reset;
    reset = 1'b1; start = 1'b0; op = 1'b0; a = '0; b = '0;
    h_start = 1'b0; h_op = 1'b0; h_a = '0; h_b = '0;
    repeat (3) @(negedge clk);
    checks++; if (sum !== 32'h0) begin errors++; $display("FAIL reset_sum: got %h expected %h", sum, 32'h0); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", done); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
`ifdef FPADD_FLAGS_EN
    checks++; if (flags !== 4'b0) begin errors++; $display("FAIL reset_flags: got %b expected 0000", flags); end
`endif
    reset = 1'b0;
  endtask

  task automatic test_basic_add;
    logic [31:0] r; int lat;
    do_op(32'h3F800000, 32'h3F800000, 1'b0, r, lat);
    checks++; if (r !== 32'h40000000) begin errors++; $display("FAIL add_1_1: got %h expected %h", r, 32'h40000000); end
    checks++; if (lat !== 6) begin errors++; $display("FAIL add_1_1_latency: got %0d expected 6", lat); end
`ifdef FPADD_FLAGS_EN
    checks++; if (flags !== 4'b0000) begin errors++; $display("FAIL add_1_1_flags: got %b expected 0000", flags); end
`endif
  endtask

  task automatic test_subtract;
    logic [31:0] r; int lat;
    do_op(32'h40400000, 32'h3F800000, 1'b1, r, lat);
    checks++; if (r !== 32'h40000000) begin errors++; $display("FAIL sub_3_1: got %h expected %h", r, 32'h40000000); end
    checks++; if (lat !== 6) begin errors++; $display("FAIL sub_3_1_latency: got %0d expected 6", lat); end
    do_op(32'h3F800000, 32'hBF800000, 1'b0, r, lat);
    checks++; if (r !== 32'h00000000) begin errors++; $display("FAIL add_1_m1: got %h expected %h", r, 32'h0); end
    do_op(32'h3F800000, 32'h40400000, 1'b1, r, lat);
    checks++; if (r !== 32'hC0000000) begin errors++; $display("FAIL sub_1_3_swap: got %h expected %h", r, 32'hC0000000); end
  endtask

  task automatic test_rounding;
    logic [31:0] r; int lat;
    do_op(32'h3F800000, 32'h33800000, 1'b0, r, lat);
    checks++; if (r !== 32'h3F800000) begin errors++; $display("FAIL round_tie_even: got %h expected %h", r, 32'h3F800000); end
`ifdef FPADD_FLAGS_EN
    checks++; if (flags !== 4'b0001) begin errors++; $display("FAIL round_tie_flags: got %b expected 0001", flags); end
`endif
    do_op(32'h3F800000, 32'h33800001, 1'b0, r, lat);
    checks++; if (r !== 32'h3F800001) begin errors++; $display("FAIL round_above_tie: got %h expected %h", r, 32'h3F800001); end
    do_op(32'h3F800000, 32'h34000000, 1'b0, r, lat);
    checks++; if (r !== 32'h3F800001) begin errors++; $display("FAIL round_exact_ulp: got %h expected %h", r, 32'h3F800001); end
    checks++; if (lat !== 6) begin errors++; $display("FAIL round_latency: got %0d expected 6", lat); end
  endtask

  task automatic test_specials;
    logic [31:0] r; int lat;
    do_op(32'h7F800000, 32'hFF800000, 1'b0, r, lat);
    checks++; if (r !== 32'h7FC00000) begin errors++; $display("FAIL inf_minus_inf: got %h expected %h", r, 32'h7FC00000); end
    checks++; if (lat !== 3) begin errors++; $display("FAIL inf_minus_inf_latency: got %0d expected 3", lat); end
`ifdef FPADD_FLAGS_EN
    checks++; if (flags !== 4'b1000) begin errors++; $display("FAIL inf_minus_inf_flags: got %b expected 1000", flags); end
`endif
    do_op(32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, r, lat);
    checks++; if (r !== 32'h7F800000) begin errors++; $display("FAIL overflow: got %h expected %h", r, 32'h7F800000); end
    checks++; if (lat !== 6) begin errors++; $display("FAIL overflow_latency: got %0d expected 6", lat); end
`ifdef FPADD_FLAGS_EN
    checks++; if (flags !== 4'b0101) begin errors++; $display("FAIL overflow_flags: got %b expected 0101", flags); end
`endif
    do_op(32'h7FC00001, 32'h3F800000, 1'b0, r, lat);
    checks++; if (r !== 32'h7FC00000) begin errors++; $display("FAIL nan_input: got %h expected %h", r, 32'h7FC00000); end
    checks++; if (lat !== 3) begin errors++; $display("FAIL nan_input_latency: got %0d expected 3", lat); end
    do_op(32'h80000000, 32'h80000000, 1'b0, r, lat);
    checks++; if (r !== 32'h80000000) begin errors++; $display("FAIL neg_zero_sum: got %h expected %h", r, 32'h80000000); end
    do_op(32'h00000001, 32'h3F800000, 1'b0, r, lat);
    checks++; if (r !== 32'h3F800000) begin errors++; $display("FAIL denormal_ftz: got %h expected %h", r, 32'h3F800000); end
    checks++; if (lat !== 3) begin errors++; $display("FAIL denormal_ftz_latency: got %0d expected 3", lat); end
    do_op(32'h00800001, 32'h00800000, 1'b1, r, lat);
    checks++; if (r !== 32'h00000000) begin errors++; $display("FAIL underflow_flush: got %h expected %h", r, 32'h0); end
`ifdef FPADD_FLAGS_EN
    checks++; if (flags !== 4'b0011) begin errors++; $display("FAIL underflow_flags: got %b expected 0011", flags); end
`endif
  endtask

  task automatic test_cancellation;
    int lat; int busy_low;
    @(negedge clk);
    a = 32'h3F800001; b = 32'h3F800000; op = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    lat = 0; busy_low = 0;
    while (done !== 1'b1 && lat < 100) begin
      if (busy !== 1'b1) busy_low++;
      @(negedge clk);
      lat++;
    end
    checks++; if (sum !== 32'h34000000) begin errors++; $display("FAIL cancel_result: got %h expected %h", sum, 32'h34000000); end
    checks++; if (lat !== 29) begin errors++; $display("FAIL cancel_latency: got %0d expected 29", lat); end
    checks++; if (busy_low !== 0) begin errors++; $display("FAIL cancel_busy: got %0d busy-low cycles expected 0", busy_low); end
  endtask

  task automatic test_back_to_back;
    int lat; int dones;
    logic [31:0] r;
    // A second start while busy, with different operands, must be ignored.
    @(negedge clk);
    a = 32'h3F800000; b = 32'h3F800000; op = 1'b0; start = 1'b1;
    @(negedge clk);
    a = 32'h40400000; b = 32'h40400000; op = 1'b1;
    @(negedge clk);
    start = 1'b0;
    lat = 1;
    while (done !== 1'b1 && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    checks++; if (sum !== 32'h40000000) begin errors++; $display("FAIL start_while_busy: got %h expected %h", sum, 32'h40000000); end
    checks++; if (lat !== 6) begin errors++; $display("FAIL start_while_busy_latency: got %0d expected 6", lat); end
    // Reset in the middle of a long normalisation aborts it.
    @(negedge clk);
    a = 32'h3F800001; b = 32'h3F800000; op = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (12) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    checks++; if (sum !== 32'h0) begin errors++; $display("FAIL midnorm_reset_sum: got %h expected %h", sum, 32'h0); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL midnorm_reset_done: got %b expected 0", done); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midnorm_reset_busy: got %b expected 0", busy); end
    reset = 1'b0;
    dones = 0;
    repeat (40) begin
      @(negedge clk);
      if (done === 1'b1) dones++;
    end
    checks++; if (dones !== 0) begin errors++; $display("FAIL aborted_op_done: got %0d done pulses expected 0", dones); end
    do_op(32'h3F800000, 32'h3F800000, 1'b0, r, lat);
    checks++; if (r !== 32'h40000000) begin errors++; $display("FAIL after_reset_result: got %h expected %h", r, 32'h40000000); end
    checks++; if (lat !== 6) begin errors++; $display("FAIL after_reset_latency: got %0d expected 6", lat); end
  endtask

  task automatic test_half_precision;
    int lat;
    @(negedge clk);
    h_a = 16'h3C00; h_b = 16'h3C00; h_op = 1'b0; h_start = 1'b1;
    @(negedge clk);
    h_start = 1'b0;
    lat = 0;
    while (h_done !== 1'b1 && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    checks++; if (h_sum !== 16'h4000) begin errors++; $display("FAIL half_add: got %h expected %h", h_sum, 16'h4000); end
    checks++; if (lat !== 6) begin errors++; $display("FAIL half_add_latency: got %0d expected 6", lat); end
  endtask

  initial begin
    test_reset();
    test_basic_add();
    test_subtract();
    test_rounding();
    test_specials();
    test_cancellation();
    test_back_to_back();
    test_half_precision();
    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
